// File: rtl/ovl_window_wrapped.sv
// Window checker: test_expr must first assert between min_cks and max_cks cycles after start_event.
// Optional build macro OVL_WINDOW_STICKY_EN makes err_early/err_late hold until rst.
module ovl_window_wrapped #(
  parameter int NUM_CKS_WIDTH = 3,
  parameter int NUM_CKS_MAX   = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_CKS_WIDTH-1:0] min_cks,
  input  logic [NUM_CKS_WIDTH-1:0] max_cks,
  input  logic                     start_event,
  input  logic                     test_expr,
  input  logic                     prevConfigInvalid,
  output logic                     out,
  output logic                     err_early,
  output logic                     err_late,
  output logic                     cfg_err,
  output logic                     busy
);

  localparam logic [NUM_CKS_WIDTH-1:0] CNT_ONE = {{(NUM_CKS_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_WINDOW} state_t;

  state_t                   r_state;
  logic [NUM_CKS_WIDTH-1:0] r_cnt;
  logic [NUM_CKS_WIDTH-1:0] r_min;
  logic [NUM_CKS_WIDTH-1:0] r_max;
  logic                     r_early;
  logic                     r_late;
  logic                     r_cfg_err;

  // Bounds above NUM_CKS_MAX cannot occur when the parameters agree; kept as a guard.
  logic w_cfg_bad;
  assign w_cfg_bad = (max_cks == '0) || (min_cks > max_cks) ||
                     ({{(32-NUM_CKS_WIDTH){1'b0}}, max_cks} > NUM_CKS_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_min     <= '0;
      r_max     <= '0;
      r_early   <= 1'b0;
      r_late    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
`ifdef OVL_WINDOW_STICKY_EN
      r_early <= r_early;
      r_late  <= r_late;
`else
      r_early <= 1'b0;
      r_late  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (enable && start_event) begin
            r_min <= min_cks;
            r_max <= max_cks;
            r_cnt <= CNT_ONE;
            if (w_cfg_bad) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_cfg_err <= 1'b0;
              r_state   <= S_WINDOW;
            end
          end
        end
        S_WINDOW: begin
          // Disable wins over any evaluation this cycle and closes silently.
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (test_expr) begin
            if (r_cnt < r_min) r_early <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_cnt == r_max) begin
            r_late  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign err_early = r_early & ~prevConfigInvalid;
  assign err_late  = r_late  & ~prevConfigInvalid;
  assign out       = (r_early | r_late) & ~prevConfigInvalid;
  assign cfg_err   = r_cfg_err;
  assign busy      = (r_state == S_WINDOW);

endmodule

// File: tb/tb_ovl_window_wrapped.sv
// Bench for ovl_window_wrapped: directed window cases plus randomized traffic against a cycle-offset model.
module tb_ovl_window_wrapped;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [2:0] min_cks = '0;
  logic [2:0] max_cks = '0;
  logic       start_event = 1'b0;
  logic       test_expr = 1'b0;
  logic       prevConfigInvalid = 1'b0;
  logic       out, err_early, err_late, cfg_err, busy;

  int n_assert = 0;
  int n_fail   = 0;

  ovl_window_wrapped #(.NUM_CKS_WIDTH(3), .NUM_CKS_MAX(7)) dut (
    .clk(clk), .rst(rst), .enable(enable), .min_cks(min_cks), .max_cks(max_cks),
    .start_event(start_event), .test_expr(test_expr), .prevConfigInvalid(prevConfigInvalid),
    .out(out), .err_early(err_early), .err_late(err_late), .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the window by absolute cycle number of its opening event.
  int  cyc = 0;
  bit  m_open = 0;
  int  m_start = 0;
  int  m_min = 0;
  int  m_max = 0;
  bit  m_cfg = 0;
  bit  m_e = 0;
  bit  m_l = 0;

`ifdef OVL_WINDOW_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  function automatic logic [1:0] judge(bit open, bit en, bit te, int off, int mn, int mx);
    if (!open || !en) return 2'b00;
    if (te) return {(off < mn), 1'b0};
    if (off == mx) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    logic [1:0] v;
    v = judge(m_open, enable, test_expr, cyc - m_start, m_min, m_max);
    if (rst) begin
      m_open <= 0; m_cfg <= 0; m_e <= 0; m_l <= 0;
    end else begin
      m_e <= (STICKY && m_e) | v[1];
      m_l <= (STICKY && m_l) | v[0];
      if (m_open) begin
        if (!enable || test_expr || (cyc - m_start) == m_max) m_open <= 0;
      end else if (enable && start_event) begin
        m_start <= cyc;
        m_min   <= int'(min_cks);
        m_max   <= int'(max_cks);
        if (max_cks == 0 || min_cks > max_cks) m_cfg <= 1;
        else begin m_cfg <= 0; m_open <= 1; end
      end
    end
    cyc <= cyc + 1;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start_event = 0; test_expr = 0; enable = 1; prevConfigInvalid = 0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_assert++;
    if ({out, err_early, err_late, cfg_err, busy} !== 5'b0) begin
      n_fail++; $display("FAIL reset: outputs=%b required 00000", {out, err_early, err_late, cfg_err, busy});
    end
  endtask

  task automatic test_pass();
    do_reset();
    min_cks = 2; max_cks = 4; start_event = 1;
    step(); start_event = 0;                      // t0+1
    n_assert++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL pass_busy_t1: busy=%b required 1", busy); end
    step();                                       // t0+2
    step(); test_expr = 1;                        // t0+3
    n_assert++;
    if (busy !== 1'b1 || out !== 1'b0) begin n_fail++; $display("FAIL pass_t3: busy=%b out=%b required 1 0", busy, out); end
    step(); test_expr = 0;                        // t0+4
    n_assert++;
    if (busy !== 1'b0 || out !== 1'b0) begin n_fail++; $display("FAIL pass_t4: busy=%b out=%b required 0 0", busy, out); end
  endtask

  task automatic test_early();
    do_reset();
    min_cks = 2; max_cks = 4; start_event = 1;
    step(); start_event = 0; test_expr = 1;       // t0+1
    step(); test_expr = 0;                        // t0+2
    n_assert++;
    if (err_early !== 1'b1 || out !== 1'b1 || busy !== 1'b0 || err_late !== 1'b0) begin
      n_fail++; $display("FAIL early_t2: early=%b out=%b busy=%b late=%b required 1 1 0 0", err_early, out, busy, err_late);
    end
    step();                                       // t0+3
    n_assert++;
    if (err_early !== STICKY || out !== STICKY) begin
      n_fail++; $display("FAIL early_t3: early=%b out=%b required %b", err_early, out, STICKY);
    end
    step(); step();
    n_assert++;
    if (err_early !== STICKY) begin n_fail++; $display("FAIL early_hold: early=%b required %b", err_early, STICKY); end
    do_reset();
    n_assert++;
    if (err_early !== 1'b0 || out !== 1'b0) begin n_fail++; $display("FAIL early_rst: early=%b out=%b required 0 0", err_early, out); end
  endtask

  task automatic test_late(input bit mask);
    do_reset();
    min_cks = 2; max_cks = 4; start_event = 1;
    step(); start_event = 0;                      // t0+1
    step(); start_event = 1;                      // t0+2, ignored
    step(); start_event = 0;                      // t0+3
    step();                                       // t0+4
    n_assert++;
    if (out !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL late_t4: out=%b busy=%b required 0 1", out, busy); end
    step();                                       // t0+5
    prevConfigInvalid = mask; #1;
    n_assert++;
    if (err_late !== !mask || out !== !mask || busy !== 1'b0) begin
      n_fail++; $display("FAIL late_t5 mask=%0d: late=%b out=%b busy=%b required %b %b 0", mask, err_late, out, busy, !mask, !mask);
    end
    step(); prevConfigInvalid = 0; #1;            // t0+6
    n_assert++;
    if (out !== STICKY || err_late !== STICKY) begin
      n_fail++; $display("FAIL late_t6 mask=%0d: out=%b late=%b required %b", mask, out, err_late, STICKY);
    end
    for (int i = 0; i < 4; i++) step();
    n_assert++;
    if (busy !== 1'b0 || out !== STICKY) begin n_fail++; $display("FAIL late_no_second: busy=%b out=%b", busy, out); end
  endtask

  task automatic test_cfg_err();
    do_reset();
    min_cks = 5; max_cks = 3; start_event = 1;
    step(); start_event = 0;
    n_assert++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || out !== 1'b0) begin
      n_fail++; $display("FAIL cfg_t1: cfg=%b busy=%b out=%b required 1 0 0", cfg_err, busy, out);
    end
    test_expr = 1; step(); test_expr = 0; step();
    n_assert++;
    if (cfg_err !== 1'b1 || out !== 1'b0) begin n_fail++; $display("FAIL cfg_hold: cfg=%b out=%b required 1 0", cfg_err, out); end
    min_cks = 0; max_cks = 1; start_event = 1;
    step(); start_event = 0;
    n_assert++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL cfg_clear: cfg=%b busy=%b required 0 1", cfg_err, busy); end
    step();
    n_assert++;
    if (err_late !== 1'b1 || out !== 1'b1) begin n_fail++; $display("FAIL cfg_late: late=%b out=%b required 1 1", err_late, out); end
    do_reset();
    max_cks = 0; min_cks = 0; start_event = 1;
    step(); start_event = 0;
    n_assert++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL cfg_max0: cfg=%b busy=%b required 1 0", cfg_err, busy); end
  endtask

  task automatic test_rst_abort();
    do_reset();
    min_cks = 2; max_cks = 4; start_event = 1;
    step(); start_event = 0;
    step(); rst = 1;
    step(); rst = 0;
    n_assert++;
    if ({out, err_early, err_late, cfg_err, busy} !== 5'b0) begin
      n_fail++; $display("FAIL rst_abort: outputs=%b required 00000", {out, err_early, err_late, cfg_err, busy});
    end
    for (int i = 0; i < 4; i++) step();
    n_assert++;
    if (out !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_no_late: out=%b busy=%b required 0 0", out, busy); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst               = ($urandom_range(0, 199) == 0);
      enable            = ($urandom_range(0, 19) != 0);
      start_event       = ($urandom_range(0, 3) == 0);
      test_expr         = ($urandom_range(0, 4) == 0);
      prevConfigInvalid = ($urandom_range(0, 9) == 0);
      min_cks           = 3'($urandom_range(0, 7));
      max_cks           = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      #1;
      n_assert++;
      if (err_early !== (m_e & ~prevConfigInvalid) || err_late !== (m_l & ~prevConfigInvalid) ||
          out !== ((m_e | m_l) & ~prevConfigInvalid) || cfg_err !== m_cfg || busy !== m_open) begin
        n_fail++;
        $display("FAIL random cyc %0d: out/early/late/cfg/busy=%b%b%b%b%b required %b%b%b%b%b", i,
                 out, err_early, err_late, cfg_err, busy,
                 (m_e | m_l) & ~prevConfigInvalid, m_e & ~prevConfigInvalid, m_l & ~prevConfigInvalid, m_cfg, m_open);
      end
      step();
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_early();
    test_late(1'b0);
    test_late(1'b1);
    test_cfg_err();
    test_rst_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
